decade_display_scan: RTL

- Downstream consumer of the cascaded decade down-counter chain.
- Snapshots the BCD digits of N cascaded decade stages, then time-multiplexes them onto one common seven-segment bus with one-hot digit enables.
- Applies optional leading-zero blanking.
- Latches the chain's most-significant borrow/overflow pulse into a sticky Alarm flag for the front panel.

---
 rtl/decade_display_scan_pkg.sv | 23 ++
 rtl/decade_display_scan_seg_decode.sv | 30 +++
 rtl/decade_display_scan.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/decade_display_scan_pkg.sv
// Shared constants for the decade display scanner.
// Holds the seven-segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
package decade_display_scan_pkg;

  typedef logic [6:0] seg_t;

  // Standard digit patterns 0..9.
  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;

  // A dash marks a non-BCD code. Off is used for blanked or dark slots.
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/decade_display_scan_seg_decode.sv
// bcd_seg_decode: combinational BCD to seven-segment decoder.
// Ports:
//   bcd  in   4-bit code, 0..9 are digits, 10..15 are illegal
//   seg  out  segment pattern {g,f,e,d,c,b,a}, active-high
// Illegal codes show a dash, so a corrupted counter is visible on the panel.
module bcd_seg_decode
  import decade_display_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/decade_display_scan.sv
// decade_display_scan: snapshots the BCD digits of a cascaded decade
// counter chain and time-multiplexes them onto one seven-segment bus.
// Ports:
//   Clock     in   sole clock, rising edge
//   Reset     in   synchronous active-high reset
//   Enable    in   1 = scan and drive display, 0 = dark, scan state holds
//   Load      in   snapshot strobe, captures Digits at this edge
//   Digits    in   packed BCD, [3:0] is the least significant stage
//   Overflow  in   single-cycle borrow pulse from the top stage
//   Clear     in   clears Alarm
//   Seg       out  registered segment drive {g,f,e,d,c,b,a}
//   An        out  registered one-hot digit enable, An[0] = least significant
//   Alarm     out  registered sticky overflow flag
//   Zero      out  registered, 1 when every snapshot digit is 0
module decade_display_scan
  import decade_display_scan_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 4,
  parameter bit BLANK    = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Digits,
  input  logic                  Overflow,
  input  logic                  Clear,
  output logic [6:0]            Seg,
  output logic [DIGITS-1:0]     An,
  output logic                  Alarm,
  output logic                  Zero
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                alarm_q, alarm_d;
  logic                zero_q, zero_d;

  logic                tick;
  logic [3:0]          digit [DIGITS];
  logic [DIGITS-1:0]   upper_nz;    // digit i or some higher digit is non-zero
  logic [DIGITS-1:0]   blank_mask;
  logic [DIGITS-1:0]   sel_onehot;
  logic [3:0]          cur_digit;
  logic                cur_blank;
  logic [6:0]          cur_seg;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit[gi] = snap_q[4*gi +: 4];
      // The least significant digit always shows, so a zero count reads "0".
      if (gi == 0) begin : g_lsd
        assign blank_mask[gi] = 1'b0;
      end else begin : g_upper
        assign blank_mask[gi] = BLANK & ~upper_nz[gi];
      end
    end
  endgenerate

  // Scan from the top digit down, accumulating "something non-zero above".
  // Any non-BCD code is non-zero here, so dashes are never blanked.
  always_comb begin
    logic nz;
    nz       = 1'b0;
    upper_nz = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz          = nz | (|snap_q[4*i +: 4]);
      upper_nz[i] = nz;
    end
  end

  // Select the active digit and its blank flag by explicit compare, which
  // stays in range for digit counts that are not a power of two.
  always_comb begin
    cur_digit  = 4'd0;
    cur_blank  = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit     = digit[i];
        cur_blank     = blank_mask[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  bcd_seg_decode u_decode (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  always_comb begin
    tick = Enable && (presc_q == PRESC_LAST);

    presc_d = presc_q;
    if (Enable) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // Snapshot capture ignores Enable so the panel can be refreshed while dark.
    snap_d = Load ? Digits : snap_q;

    // Derived from the current snapshot, so it trails a Load by one cycle.
    zero_d = (snap_q == '0);

    // Set has priority over Clear so a pulse arriving with Clear is kept.
    if (Overflow) begin
      alarm_d = 1'b1;
    end else if (Clear) begin
      alarm_d = 1'b0;
    end else begin
      alarm_d = alarm_q;
    end

    // Blanked slots keep their enable so every digit gets the same duty cycle.
    an_d  = '0;
    seg_d = SEG_OFF;
    if (Enable) begin
      an_d  = sel_onehot;
      seg_d = cur_blank ? SEG_OFF : cur_seg;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= '0;
      alarm_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      alarm_q <= alarm_d;
      zero_q  <= zero_d;
    end
  end

  assign Seg   = seg_q;
  assign An    = an_q;
  assign Alarm = alarm_q;
  assign Zero  = zero_q;

endmodule
